// File: rtl/mcpu5_prog_server_if.sv
// Bus bundle between the MCPU5 core side, the program loader, the run controller and the
// output drain of mcpu5_prog_server.
interface mcpu5_prog_server_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned INST_W = 6
);
  logic [ADDR_W-1:0] cpu_addr;
  logic [INST_W-1:0] cpu_inst;
  logic              cpu_reset;
  logic              ld_valid;
  logic              ld_ready;
  logic [INST_W-1:0] ld_data;
  logic              ld_last;
  logic              run_start;
  logic              run_stop;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_data;
  logic [1:0]        state;
  logic              overflow;
  logic              timeout;

  // Server view
  modport slave (
    input  cpu_addr, ld_valid, ld_data, ld_last, run_start, run_stop, out_ready,
    output cpu_inst, cpu_reset, ld_ready, out_valid, out_data, state, overflow, timeout
  );

  // Host / CPU view
  modport master (
    output cpu_addr, ld_valid, ld_data, ld_last, run_start, run_stop, out_ready,
    input  cpu_inst, cpu_reset, ld_ready, out_valid, out_data, state, overflow, timeout
  );
endinterface

// File: rtl/mcpu5_prog_server.sv
// Program server for the MCPU5 fetch bus: loadable program RAM with zero-latency fetch,
// OUT-value capture FIFO, CPU reset control and a run-cycle watchdog.
module mcpu5_prog_server #(
  parameter int unsigned       ADDR_W      = 8,
  parameter int unsigned       INST_W      = 6,
  parameter logic [INST_W-1:0] OUT_OPC     = 6'b111011,
  parameter logic [INST_W-1:0] IDLE_INST   = 6'b111001,
  parameter int unsigned       FIFO_DEPTH  = 8,
  parameter int unsigned       CYCLE_LIMIT = 10000
) (
  input logic                i_clk,
  input logic                i_reset,
  mcpu5_prog_server_if.slave io_bus
);

  localparam int unsigned RAM_DEPTH = 2 ** ADDR_W;
  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    StLoad = 2'd0,
    StArm  = 2'd1,
    StRun  = 2'd2,
    StHalt = 2'd3
  } state_e;

  state_e              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_wptr, w_wptr_nxt;
  logic [31:0]         r_cnt, w_cnt_nxt;
  logic                r_cpu_reset;
  logic                r_pend, w_pend_nxt;
  logic                r_ovf, r_to;
  logic                w_to_set, w_clear;
  logic [INST_W-1:0]   r_mem [RAM_DEPTH];
  logic [ADDR_W-1:0]   r_fifo [FIFO_DEPTH];
  // Extra MSB on the FIFO pointers distinguishes full from empty.
  logic [PTR_W:0]      r_rd, r_wr;
  logic [PTR_W:0]      w_fifo_cnt;
  logic                w_empty, w_full, w_pop, w_push, w_drop, w_accept;
  logic [INST_W-1:0]   w_inst;

  assign w_inst     = (r_state == StRun) ? r_mem[io_bus.cpu_addr] : IDLE_INST;
  assign w_accept   = (r_state == StLoad) && io_bus.ld_valid;
  assign w_fifo_cnt = r_wr - r_rd;
  assign w_empty    = (w_fifo_cnt == '0);
  assign w_full     = (w_fifo_cnt == (PTR_W + 1)'(FIFO_DEPTH));
  assign w_pop      = io_bus.out_ready && !w_empty;
  // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
  assign w_push     = r_pend && (!w_full || w_pop);
  assign w_drop     = r_pend && w_full && !w_pop;

  // Next-state logic for the load/arm/run/halt sequencer
  always_comb begin
    w_state_nxt = r_state;
    w_wptr_nxt  = r_wptr;
    w_cnt_nxt   = r_cnt;
    w_to_set    = 1'b0;
    w_clear     = 1'b0;
    unique case (r_state)
      StLoad: begin
        if (w_accept) begin
          if (io_bus.ld_last || (r_wptr == {ADDR_W{1'b1}})) begin
            w_state_nxt = StArm;
          end else begin
            w_wptr_nxt = r_wptr + 1'b1;
          end
        end
      end
      StArm: begin
        if (io_bus.run_start) begin
          w_state_nxt = StRun;
          w_cnt_nxt   = '0;
        end
      end
      StRun: begin
        w_cnt_nxt = r_cnt + 32'd1;
        if (io_bus.run_stop) begin
          w_state_nxt = StHalt;
        end else if ((CYCLE_LIMIT != 0) && (r_cnt == CYCLE_LIMIT - 1)) begin
          w_state_nxt = StHalt;
          w_to_set    = 1'b1;
        end
      end
      StHalt: begin
        if (io_bus.run_start) begin
          w_state_nxt = StRun;
          w_cnt_nxt   = '0;
          w_clear     = 1'b1;
        end
      end
      default: ;
    endcase
    // Capture only arms while staying in RUN; leaving RUN drops any pending capture.
    w_pend_nxt = (r_state == StRun) && (w_state_nxt == StRun) && (w_inst == OUT_OPC);
  end

  // Control state, FIFO pointers and sticky flags
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= StLoad;
      r_wptr      <= '0;
      r_cnt       <= '0;
      r_cpu_reset <= 1'b1;
      r_pend      <= 1'b0;
      r_ovf       <= 1'b0;
      r_to        <= 1'b0;
      r_rd        <= '0;
      r_wr        <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_wptr      <= w_wptr_nxt;
      r_cnt       <= w_cnt_nxt;
      r_cpu_reset <= (w_state_nxt != StRun);
      r_pend      <= w_pend_nxt;
      if (w_clear) begin
        r_ovf <= 1'b0;
        r_to  <= 1'b0;
      end else begin
        if (w_drop)   r_ovf <= 1'b1;
        if (w_to_set) r_to  <= 1'b1;
      end
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  // Program RAM and FIFO storage; contents survive reset
  always_ff @(posedge i_clk) begin
    if (!i_reset && w_accept) r_mem[r_wptr] <= io_bus.ld_data;
    if (!i_reset && w_push)   r_fifo[r_wr[PTR_W-1:0]] <= io_bus.cpu_addr;
  end

  assign io_bus.cpu_inst  = w_inst;
  assign io_bus.cpu_reset = r_cpu_reset;
  assign io_bus.ld_ready  = (r_state == StLoad);
  assign io_bus.out_valid = !w_empty;
  assign io_bus.out_data  = r_fifo[r_rd[PTR_W-1:0]];
  assign io_bus.state     = r_state;
  assign io_bus.overflow  = r_ovf;
  assign io_bus.timeout   = r_to;

endmodule

// File: tb/tb_mcpu5_prog_server.sv
// Self-checking bench for mcpu5_prog_server: directed table, hand sequences for the
// multi-cycle corners, and randomized traffic checked against a behavioural model.
module tb_mcpu5_prog_server;

  localparam logic [5:0] OUT_I  = 6'h3B;
  localparam logic [5:0] IDLE_I = 6'h39;
  localparam int         LIMIT  = 16;
  localparam int         DEPTH  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mcpu5_prog_server_if #(.ADDR_W(8), .INST_W(6)) u_if ();

  mcpu5_prog_server #(
    .ADDR_W(8), .INST_W(6), .OUT_OPC(OUT_I), .IDLE_INST(IDLE_I),
    .FIFO_DEPTH(DEPTH), .CYCLE_LIMIT(LIMIT)
  ) u_dut (
    .i_clk  (clk),
    .i_reset(rst),
    .io_bus (u_if)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Behavioural model
  bit         m_live = 0;
  int         m_state;
  logic [5:0] m_mem [256];
  int         m_wptr;
  bit         m_cres, m_pend, m_ovf, m_to;
  int         m_runs;
  logic [7:0] m_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [5:0] m_inst();
    return (m_state == 2) ? m_mem[u_if.cpu_addr] : IDLE_I;
  endfunction

  task automatic check_model();
    chk("m_state", {30'd0, u_if.state}, m_state);
    chk("m_cpu_inst", {26'd0, u_if.cpu_inst}, {26'd0, m_inst()});
    chk("m_cpu_reset", {31'd0, u_if.cpu_reset}, {31'd0, m_cres});
    chk("m_ld_ready", {31'd0, u_if.ld_ready}, (m_state == 0) ? 1 : 0);
    chk("m_out_valid", {31'd0, u_if.out_valid}, (m_q.size() != 0) ? 1 : 0);
    if (m_q.size() != 0) chk("m_out_data", {24'd0, u_if.out_data}, {24'd0, m_q[0]});
    chk("m_overflow", {31'd0, u_if.overflow}, {31'd0, m_ovf});
    chk("m_timeout", {31'd0, u_if.timeout}, {31'd0, m_to});
  endtask

  // Advance the model across one clock edge using the currently driven inputs.
  task automatic model_step();
    logic [5:0] inst;
    int ns;
    if (rst) begin
      m_live = 1; m_state = 0; m_wptr = 0; m_cres = 1; m_pend = 0;
      m_runs = 0; m_ovf = 0; m_to = 0; m_q.delete();
      return;
    end
    inst = m_inst();
    ns   = m_state;
    if (u_if.out_ready && m_q.size() > 0) void'(m_q.pop_front());
    if (m_pend) begin
      if (m_q.size() < DEPTH) m_q.push_back(u_if.cpu_addr);
      else m_ovf = 1;
    end
    case (m_state)
      0: if (u_if.ld_valid) begin
           m_mem[m_wptr] = u_if.ld_data;
           if (u_if.ld_last || m_wptr == 255) ns = 1;
           else m_wptr++;
         end
      1: if (u_if.run_start) begin ns = 2; m_runs = 0; end
      2: begin
           m_runs++;
           if (u_if.run_stop) ns = 3;
           else if (m_runs == LIMIT) begin ns = 3; m_to = 1; end
         end
      default: if (u_if.run_start) begin ns = 2; m_runs = 0; m_ovf = 0; m_to = 0; end
    endcase
    m_pend  = (m_state == 2) && (ns == 2) && (inst == OUT_I);
    m_state = ns;
    m_cres  = (ns != 2);
  endtask

  // Called 2 time units after inputs change; returns 1 after the next rising edge.
  task automatic cycle();
    if (m_live) check_model();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    u_if.cpu_addr = '0; u_if.ld_valid = 0; u_if.ld_data = '0; u_if.ld_last = 0;
    u_if.run_start = 0; u_if.run_stop = 0; u_if.out_ready = 0;
  endtask

  task automatic step();
    #2;
    cycle();
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  task automatic load3();
    logic [5:0] w [3];
    w[0] = 6'h05; w[1] = 6'h2A; w[2] = 6'h3B;
    for (int i = 0; i < 3; i++) begin
      u_if.ld_valid = 1; u_if.ld_data = w[i]; u_if.ld_last = (i == 2);
      step();
    end
    idle();
  endtask

  typedef struct {
    logic [7:0] addr;
    bit         ldv;
    logic [5:0] ldd;
    bit         ldl;
    bit         start;
    bit         ordy;
    logic [1:0] e_state;
    logic [5:0] e_inst;
    bit         e_ldr;
    bit         e_cres;
    bit         e_ov;
    logic [7:0] e_od;
  } vec_t;

  vec_t tbl [11];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         drained;
    logic [7:0] cap [10];
    idle();

    // Stream 256 words without ld_last; pattern (i*5+1)%64.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      u_if.ld_valid = 1; u_if.ld_data = 6'((i * 5 + 1) % 64);
      #2;
      if (i == 255) chk("t5_load_before_last", {30'd0, u_if.state}, 0);
      cycle();
    end
    idle();
    #2;
    chk("t5_arm_after_256", {30'd0, u_if.state}, 1);
    chk("t5_ld_ready_low", {31'd0, u_if.ld_ready}, 0);
    cycle();
    u_if.run_start = 1;
    step();
    u_if.run_start = 0;
    #2;
    chk("t5_mem00", {26'd0, u_if.cpu_inst}, 32'h01);
    u_if.cpu_addr = 8'hFF;
    #1;
    chk("t5_memFF", {26'd0, u_if.cpu_inst}, 32'h3C);
    cycle();

    // Tests 1 and 2: table-driven load, run and single OUT capture.
    do_reset();
    tbl[0]  = '{8'h00, 1, 6'h05, 0, 0, 0, 2'd0, IDLE_I, 1, 1, 0, 8'h00};
    tbl[1]  = '{8'h00, 1, 6'h2A, 0, 0, 0, 2'd0, IDLE_I, 1, 1, 0, 8'h00};
    tbl[2]  = '{8'h00, 1, 6'h3B, 1, 0, 0, 2'd0, IDLE_I, 1, 1, 0, 8'h00};
    tbl[3]  = '{8'h00, 0, 6'h00, 0, 0, 0, 2'd1, IDLE_I, 0, 1, 0, 8'h00};
    tbl[4]  = '{8'h01, 0, 6'h00, 0, 1, 0, 2'd1, IDLE_I, 0, 1, 0, 8'h00};
    tbl[5]  = '{8'h01, 0, 6'h00, 0, 0, 0, 2'd2, 6'h2A,  0, 0, 0, 8'h00};
    tbl[6]  = '{8'h02, 0, 6'h00, 0, 0, 0, 2'd2, 6'h3B,  0, 0, 0, 8'h00};
    tbl[7]  = '{8'h5A, 0, 6'h00, 0, 0, 0, 2'd2, 6'h03,  0, 0, 0, 8'h00};
    tbl[8]  = '{8'h01, 0, 6'h00, 0, 0, 0, 2'd2, 6'h2A,  0, 0, 1, 8'h5A};
    tbl[9]  = '{8'h01, 0, 6'h00, 0, 0, 1, 2'd2, 6'h2A,  0, 0, 1, 8'h5A};
    tbl[10] = '{8'h01, 0, 6'h00, 0, 0, 0, 2'd2, 6'h2A,  0, 0, 0, 8'h00};
    for (int i = 0; i < 11; i++) begin
      u_if.cpu_addr = tbl[i].addr; u_if.ld_valid = tbl[i].ldv; u_if.ld_data = tbl[i].ldd;
      u_if.ld_last = tbl[i].ldl; u_if.run_start = tbl[i].start; u_if.out_ready = tbl[i].ordy;
      #2;
      chk($sformatf("tbl%0d_state", i), {30'd0, u_if.state}, {30'd0, tbl[i].e_state});
      chk($sformatf("tbl%0d_inst", i), {26'd0, u_if.cpu_inst}, {26'd0, tbl[i].e_inst});
      chk($sformatf("tbl%0d_ld_ready", i), {31'd0, u_if.ld_ready}, {31'd0, tbl[i].e_ldr});
      chk($sformatf("tbl%0d_cpu_reset", i), {31'd0, u_if.cpu_reset}, {31'd0, tbl[i].e_cres});
      chk($sformatf("tbl%0d_out_valid", i), {31'd0, u_if.out_valid}, {31'd0, tbl[i].e_ov});
      if (tbl[i].e_ov) chk($sformatf("tbl%0d_out_data", i), {24'd0, u_if.out_data},
                           {24'd0, tbl[i].e_od});
      cycle();
    end
    idle();

    // Test 3: 9 captures into an 8-deep FIFO, then full push with simultaneous pop.
    u_if.run_stop = 1; step(); u_if.run_stop = 0;
    u_if.run_start = 1; step(); u_if.run_start = 0;
    cap[0] = 8'd2; cap[1] = 8'd50; cap[2] = 8'd114; cap[3] = 8'd178; cap[4] = 8'd242;
    cap[5] = 8'd2; cap[6] = 8'd50; cap[7] = 8'd114; cap[8] = 8'd178; cap[9] = 8'd242;
    for (int k = 0; k < 10; k++) begin
      u_if.cpu_addr = cap[k];
      step();
    end
    u_if.cpu_addr = 8'h00;
    #2;
    chk("t3_overflow_set", {31'd0, u_if.overflow}, 1);
    chk("t3_head", {24'd0, u_if.out_data}, 50);
    cycle();
    u_if.run_stop = 1; step(); u_if.run_stop = 0;
    u_if.run_start = 1; #2;
    chk("t3_halt_keeps_fifo", {31'd0, u_if.out_valid}, 1);
    cycle();
    u_if.run_start = 0;
    u_if.cpu_addr = 8'd2; #2;
    chk("t3_restart_clears_ovf", {31'd0, u_if.overflow}, 0);
    cycle();
    u_if.cpu_addr = 8'h77; u_if.out_ready = 1; step();
    u_if.cpu_addr = 8'h00; u_if.out_ready = 0; #2;
    chk("t3_full_pushpop_no_ovf", {31'd0, u_if.overflow}, 0);
    chk("t3_head_after_pop", {24'd0, u_if.out_data}, 114);
    cycle();
    drained = 0;
    u_if.out_ready = 1;
    for (int k = 0; k < 12; k++) begin
      #2;
      if (u_if.out_valid) drained++;
      cycle();
    end
    u_if.out_ready = 0;
    chk("t3_drained_count", drained, 8);

    // Test 4: run-cycle limit.
    u_if.run_stop = 1; step(); u_if.run_stop = 0;
    u_if.run_start = 1; step(); u_if.run_start = 0;
    for (int k = 0; k < LIMIT; k++) begin
      #2;
      if (k == LIMIT - 1) chk("t4_run_at_last", {30'd0, u_if.state}, 2);
      cycle();
    end
    #2;
    chk("t4_halt", {30'd0, u_if.state}, 3);
    chk("t4_timeout", {31'd0, u_if.timeout}, 1);
    chk("t4_cpu_reset", {31'd0, u_if.cpu_reset}, 1);
    chk("t4_idle_inst", {26'd0, u_if.cpu_inst}, {26'd0, IDLE_I});
    cycle();
    u_if.run_start = 1; step(); u_if.run_start = 0; #2;
    chk("t4_restart_clears_to", {31'd0, u_if.timeout}, 0);
    cycle();

    // Test 6: reset with a pending capture and three queued entries.
    do_reset();
    load3();
    u_if.run_start = 1; step(); u_if.run_start = 0;
    cap[0] = 8'd2; cap[1] = 8'd50; cap[2] = 8'd114; cap[3] = 8'd2;
    for (int k = 0; k < 4; k++) begin
      u_if.cpu_addr = cap[k];
      step();
    end
    rst = 1; u_if.cpu_addr = 8'h99; u_if.out_ready = 0; step();
    rst = 0; #2;
    chk("t6_state_load", {30'd0, u_if.state}, 0);
    chk("t6_fifo_empty", {31'd0, u_if.out_valid}, 0);
    cycle();
    #2;
    chk("t6_no_late_push", {31'd0, u_if.out_valid}, 0);
    cycle();

    // Randomized traffic after a full random program load.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      u_if.ld_valid = 1;
      u_if.ld_data  = ($urandom_range(0, 9) < 3) ? OUT_I : 6'($urandom_range(0, 63));
      step();
    end
    idle();
    for (int i = 0; i < 3000; i++) begin
      rst            = ($urandom_range(0, 299) == 0);
      u_if.cpu_addr  = 8'($urandom_range(0, 255));
      u_if.ld_valid  = 1'($urandom_range(0, 1));
      u_if.ld_data   = ($urandom_range(0, 9) < 3) ? OUT_I : 6'($urandom_range(0, 63));
      u_if.ld_last   = ($urandom_range(0, 15) == 0);
      u_if.run_start = ($urandom_range(0, 3) == 0);
      u_if.run_stop  = ($urandom_range(0, 15) == 0);
      u_if.out_ready = 1'($urandom_range(0, 1));
      step();
    end
    rst = 0;
    idle();
    #2;
    check_model();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
